// File: rtl/sound_event_scheduler.sv
// sound_event_scheduler
//   Latches dragon-collision events into per-source pending flags and plays
//   one tone at a time by fixed priority (player > sword > sheep). Each tone
//   lasts a parameterised number of video frames and is followed by a silent
//   gap before the next grant.
//
//   Optional feature macro: SOUND_PREEMPT_EN
//     defined   -> a strictly higher-priority pending request interrupts the
//                  current tone or gap and is granted on the next edge; the
//                  interrupted tone is dropped.
//     undefined -> every tone and its gap run to completion.
//
// Ports
//   clk                    in   system clock, rising edge
//   reset                  in   synchronous, active-low
//   SheepDragonCollision   in   event request, low priority
//   SwordDragonCollision   in   event request, mid priority
//   PlayerDragonCollision  in   event request, high priority
//   frame_end              in   one-cycle pulse per video frame
//   tone_code       [1:0]  out  0 none, 1 sheep, 2 sword, 3 player
//   tone_active            out  high while a tone plays
//   busy                   out  high whenever not IDLE
//   pending         [2:0]  out  latched requests {player, sword, sheep}
module sound_event_scheduler #(
    parameter int DUR_PLAYER = 30,
    parameter int DUR_SWORD  = 12,
    parameter int DUR_SHEEP  = 20,
    parameter int GAP_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SheepDragonCollision,
    input  logic       SwordDragonCollision,
    input  logic       PlayerDragonCollision,
    input  logic       frame_end,
    output logic [1:0] tone_code,
    output logic       tone_active,
    output logic       busy,
    output logic [2:0] pending
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam logic [5:0] DUR_P = 6'(DUR_PLAYER);
    localparam logic [5:0] DUR_W = 6'(DUR_SWORD);
    localparam logic [5:0] DUR_S = 6'(DUR_SHEEP);
    localparam logic [5:0] GAP_N = 6'(GAP_FRAMES);

    state_t     state, state_n;
    logic [5:0] cnt, cnt_n;
    logic [1:0] code_n;
    logic [1:0] last, last_n;   // code of the tone most recently granted
    logic [2:0] events;
    logic [2:0] pend_n;
    logic [2:0] grant;
    logic [2:0] pgrant;         // one-hot highest-priority pending source
    logic [1:0] pcode;          // its tone code (0 when nothing pending)
    logic [5:0] pdur;
    logic       take;

    assign events = {PlayerDragonCollision, SwordDragonCollision, SheepDragonCollision};

    always_comb begin
        pgrant = 3'b000;
        pcode  = 2'd0;
        pdur   = DUR_S;
        if (pending[2]) begin
            pgrant = 3'b100; pcode = 2'd3; pdur = DUR_P;
        end else if (pending[1]) begin
            pgrant = 3'b010; pcode = 2'd2; pdur = DUR_W;
        end else if (pending[0]) begin
            pgrant = 3'b001; pcode = 2'd1; pdur = DUR_S;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        code_n  = tone_code;
        last_n  = last;
        take    = 1'b0;
        grant   = 3'b000;

        case (state)
            IDLE: begin
                code_n = 2'd0;
                if (pcode != 2'd0) take = 1'b1;
            end
            PLAY: begin
                if (frame_end) begin
                    if (cnt == 6'd1) begin
                        code_n = 2'd0;
                        if (GAP_N == 6'd0) begin
                            state_n = IDLE;
                        end else begin
                            state_n = GAP;
                            cnt_n   = GAP_N;
                        end
                    end else if (cnt != 6'd0) begin
                        cnt_n = cnt - 6'd1;
                    end
                end
            end
            GAP: begin
                if (frame_end) begin
                    if (cnt == 6'd1) state_n = IDLE;
                    else if (cnt != 6'd0) cnt_n = cnt - 6'd1;
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef SOUND_PREEMPT_EN
        // Only strictly higher priority interrupts; pcode ordering matches priority.
        if (state != IDLE && pcode > last) take = 1'b1;
`endif

        // A grant wins over any frame_end counting in the same cycle.
        if (take) begin
            grant   = pgrant;
            state_n = PLAY;
            cnt_n   = pdur;
            code_n  = pcode;
            last_n  = pcode;
        end

        // An event coincident with its own grant re-latches for a later replay.
        pend_n = events | (pending & ~grant);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            tone_code <= 2'd0;
            last      <= 2'd0;
            pending   <= 3'b000;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            tone_code <= code_n;
            last      <= last_n;
            pending   <= pend_n;
        end
    end

    assign tone_active = (state == PLAY);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Directed bench for sound_event_scheduler. Main instance uses default
// parameters; a second instance with GAP_FRAMES = 0 covers back-to-back grants.
module tb_sound_event_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       sheep, sword, player, frame_end;
    logic [1:0] tone_code, tone_code0;
    logic       tone_active, tone_active0;
    logic       busy, busy0;
    logic [2:0] pending, pending0;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sound_event_scheduler u_dut (
        .clk(clk), .reset(reset),
        .SheepDragonCollision(sheep), .SwordDragonCollision(sword),
        .PlayerDragonCollision(player), .frame_end(frame_end),
        .tone_code(tone_code), .tone_active(tone_active),
        .busy(busy), .pending(pending)
    );

    sound_event_scheduler #(.GAP_FRAMES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .SheepDragonCollision(sheep), .SwordDragonCollision(sword),
        .PlayerDragonCollision(player), .frame_end(frame_end),
        .tone_code(tone_code0), .tone_active(tone_active0),
        .busy(busy0), .pending(pending0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame_end pulse, then sp-1 quiet cycles.
    task automatic frame(input int sp);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        repeat (sp - 1) tick();
    endtask

    // Runs nframes remaining tone frames then gap frames on the main instance.
    task automatic play(input logic [1:0] code, input int nframes, input int gap, input int sp);
        for (int i = 1; i <= nframes; i++) begin
            frame(sp);
            if (i < nframes) begin
                check("play_code", tone_code, code);
                check("play_active", tone_active, 1'b1);
            end else begin
                check("end_code", tone_code, 2'd0);
                check("end_active", tone_active, 1'b0);
                check("end_busy", busy, gap != 0);
            end
        end
        for (int j = 1; j <= gap; j++) begin
            frame(sp);
            check("gap_busy", busy, j < gap);
            check("gap_active", tone_active, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; sheep = 1'b1; sword = 1'b0; player = 1'b0; frame_end = 1'b0;

        // Reset held with an event active
        repeat (3) tick();
        check("rst_code", tone_code, 2'd0);
        check("rst_active", tone_active, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pending", pending, 3'b000);
        reset = 1'b1;
        tick();
        check("lat_pending", pending, 3'b001);
        check("lat_code", tone_code, 2'd0);
        sheep = 1'b0;
        tick();
        check("grant_code", tone_code, 2'd1);
        check("grant_active", tone_active, 1'b1);
        check("grant_pending", pending, 3'b000);

        // Sheep tone with frame_end every 10 cycles: 20 frames + 4 gap
        play(2'd1, 20, 4, 10);
        tick();
        check("idle_code", tone_code, 2'd0);
        check("idle_busy", busy, 1'b0);

        // All three in one cycle: served 3, 2, 1
        sheep = 1'b1; sword = 1'b1; player = 1'b1;
        tick();
        sheep = 1'b0; sword = 1'b0; player = 1'b0;
        check("all_pending", pending, 3'b111);
        tick();
        check("all_code3", tone_code, 2'd3);
        check("all_pend011", pending, 3'b011);
        play(2'd3, 30, 4, 1);
        check("all_wait_pend", pending, 3'b011);
        tick();
        check("all_code2", tone_code, 2'd2);
        check("all_pend001", pending, 3'b001);
        play(2'd2, 12, 4, 1);
        tick();
        check("all_code1", tone_code, 2'd1);
        check("all_pend000", pending, 3'b000);
        play(2'd1, 20, 4, 1);

        // Reset mid-PLAY at frame 5 of 30, with a sword request pending
        player = 1'b1; tick(); player = 1'b0; tick();
        check("mid_code", tone_code, 2'd3);
        repeat (5) frame(1);
        sword = 1'b1; tick(); sword = 1'b0;
        check("mid_pending", pending, 3'b010);
        reset = 1'b0; tick();
        check("mid_rst_code", tone_code, 2'd0);
        check("mid_rst_active", tone_active, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_pending", pending, 3'b000);
        reset = 1'b1; tick();
        check("mid_after_busy", busy, 1'b0);

        // Sheep playing, player request at frame 3
        sheep = 1'b1; tick(); sheep = 1'b0; tick();
        check("pre_code1", tone_code, 2'd1);
        repeat (3) frame(1);
        player = 1'b1; tick(); player = 1'b0;
        check("pre_pending", pending, 3'b100);
        check("pre_still1", tone_code, 2'd1);
`ifdef SOUND_PREEMPT_EN
        tick();
        check("pre_code3", tone_code, 2'd3);
        check("pre_cleared", pending, 3'b000);
        play(2'd3, 30, 4, 1);
        tick();
        check("pre_no_resume", tone_code, 2'd0);
        check("pre_no_resume_busy", busy, 1'b0);
`else
        play(2'd1, 17, 4, 1);
        check("wait_pending", pending, 3'b100);
        tick();
        check("wait_code3", tone_code, 2'd3);
        play(2'd3, 30, 4, 1);
        tick();
        check("wait_idle", busy, 1'b0);
`endif

        // Sword re-pulsed on its own grant cycle -> plays twice
        sword = 1'b1; tick();
        check("rep_latch", pending, 3'b010);
        tick(); sword = 1'b0;
        check("rep_code", tone_code, 2'd2);
        check("rep_relatch", pending, 3'b010);
        play(2'd2, 12, 4, 1);
        check("rep_wait", pending, 3'b010);
        tick();
        check("rep_code2", tone_code, 2'd2);
        check("rep_cleared", pending, 3'b000);
        play(2'd2, 12, 4, 1);

        // GAP_FRAMES = 0 instance: second tone the cycle after the first ends
        reset = 1'b0; tick(); reset = 1'b1;
        sword = 1'b1; tick(); tick(); sword = 1'b0;
        check("g0_code", tone_code0, 2'd2);
        check("g0_relatch", pending0, 3'b010);
        for (int i = 1; i <= 12; i++) begin
            frame(1);
            if (i < 12) check("g0_play", tone_code0, 2'd2);
        end
        check("g0_end_active", tone_active0, 1'b0);
        check("g0_end_busy", busy0, 1'b0);
        tick();
        check("g0_code2", tone_code0, 2'd2);
        check("g0_active2", tone_active0, 1'b1);
        check("g0_cleared", pending0, 3'b000);
        repeat (12) frame(1);
        check("g0_done", busy0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/sound_event_scheduler.md
# sound_event_scheduler

Arbitrates and sequences game sound events for the audio path. It latches collision events from the game logic into per-source pending flags. It grants one event at a time by fixed priority and holds the selected tone for a frame-counted duration, followed by a silent gap. It sits between the collision detectors and AudioProcessingUnit, which it drives through `tone_code` and `tone_active`.

## Interface
Parameters:
- `DUR_PLAYER`, default 30: tone length in frames for a player/dragon collision; legal range 1–63.
- `DUR_SWORD`, default 12: tone length in frames for a sword/dragon collision; legal range 1–63.
- `DUR_SHEEP`, default 20: tone length in frames for a sheep/dragon collision; legal range 1–63.
- `GAP_FRAMES`, default 4: silent frames after each tone; legal range 0–63.

Ports:
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-low reset.
- `SheepDragonCollision` input 1: event request, priority low.
- `SwordDragonCollision` input 1: event request, priority mid.
- `PlayerDragonCollision` input 1: event request, priority high.
- `frame_end` input 1: one-cycle pulse, once per video frame.
- `tone_code` output 2: current tone; 0 = none, 1 = sheep, 2 = sword, 3 = player.
- `tone_active` output 1: high while a tone is playing.
- `busy` output 1: high when the state is not IDLE.
- `pending` output 3: latched requests as {player, sword, sheep}.

## Operation
- Pending flags: `pending[i]` next = `event[i] | (pending[i] & ~grant[i])`.
  - An event that is high on the grant cycle of the same source re-latches, so that source plays again later.
  - An event held high stays pending.
- State machine IDLE / PLAY / GAP, with a 6-bit frame counter `cnt`.
- IDLE:
  - If any pending flag is set, grant the highest-priority one (player > sword > sheep).
  - Clear its pending flag, load `tone_code`, set `cnt` = duration for that source, go to PLAY.
  - If nothing is pending, stay in IDLE with `tone_code` = 0.
- PLAY:
  - `tone_active` = 1.
  - On `frame_end`: if `cnt` == 1, end the tone. Otherwise decrement `cnt`.
  - Ending the tone: if `GAP_FRAMES` == 0, go to IDLE. Otherwise go to GAP with `cnt` = `GAP_FRAMES`.
  - In both cases `tone_code` goes to 0 and `tone_active` goes to 0.
- GAP:
  - On `frame_end`: if `cnt` == 1, go to IDLE. Otherwise decrement `cnt`.
- `cnt` never wraps. A value of 0 is never loaded in PLAY, which the legal parameter range guarantees.
- Reset, including mid-tone, gives: state IDLE, `cnt` = 0, `pending` = 0, `tone_code` = 0, `tone_active` = 0, `busy` = 0.

## Timing
- Event high in cycle N → `pending` set at edge N+1 → PLAY, `tone_code` valid and `tone_active` = 1 from edge N+2. This assumes IDLE and no higher-priority request.
- Each tone lasts exactly DUR `frame_end` pulses. `tone_active` falls on the edge that samples the DUR-th `frame_end`.
- Back-to-back requests: the next grant happens the cycle after GAP exits to IDLE. With `GAP_FRAMES` = 0 it happens the cycle after PLAY ends.
- Simultaneous events in the same cycle: all of them latch, and they are served in priority order.
- A `frame_end` in the same cycle as a grant is not counted.

## Configuration
- `SOUND_PREEMPT_EN` defined:
  - In PLAY or GAP, a pending request of strictly higher priority than the current or last tone causes an immediate re-grant on the next edge.
  - The re-grant clears that pending flag, reloads `cnt`, updates `tone_code`, and enters PLAY.
  - The interrupted tone is dropped and not re-queued.
  - Equal or lower priority never preempts.
- `SOUND_PREEMPT_EN` undefined:
  - Every tone plus its gap runs to completion.
  - Higher-priority requests wait in `pending`.

## Test plan
- Reset: hold `reset` = 0 for 3 cycles with an event active → all outputs 0. After release, the event pulse yields `tone_code` = 1 two cycles later.
- Sheep pulse, `frame_end` every 10 cycles → `tone_active` for 20 frame pulses with `tone_code` = 1, then 4 gap frames with `busy` = 1, then IDLE.
- All three events in one cycle → tones play in the order 3, 2, 1, each followed by a 4-frame gap; `pending` goes 111 → 011 → 001 → 000.
- Reset asserted mid-PLAY (frame 5 of 30) → next cycle IDLE, `tone_code` = 0, `pending` = 0.
- Sheep playing, then a player pulse at frame 3 → without `SOUND_PREEMPT_EN`, sheep completes 20 frames plus the gap, then `tone_code` = 3; with it, `tone_code` = 3 two cycles after the pulse and the sheep tone is never resumed.
- Sword event re-pulsed on its own grant cycle → sword plays twice; `GAP_FRAMES` = 0 build → second tone starts the cycle after the first ends.
